residual_reconstruct: RTL and testbench
=======================================

# residual_reconstruct

Reconstruction stage directly downstream of the camera decoder's inverse quantisation/transform stage. On `start` it captures one residual block, the matching prediction block and the block size. It then adds residual to prediction per sample, clips each sum to the pixel range, and streams the reconstructed block out one row per cycle over a valid/ready interface. Its output feeds the frame-buffer writer.

## Interface
- `COEFF_WIDTH`, 16, signed residual sample width
- `MAX_SIZE`, 32, maximum block edge in samples
- `BIT_DEPTH`, 8, unsigned pixel width for prediction and output
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  level; sampled only in IDLE
- `done`  out  1  block fully emitted; held until `start` is low
- `transform_size`  in  2  block size: 0→4, 1→8, 2→16, 3→32; captured with `start`
- `residual_data`  in  signed [COEFF_WIDTH-1:0] [MAX_SIZE][MAX_SIZE]  residual block from the inverse transform
- `pred_data`  in  [BIT_DEPTH-1:0] [MAX_SIZE][MAX_SIZE]  prediction block
- `out_valid`  out  1  `out_row` holds a valid row
- `out_ready`  in  1  consumer accepts the row on `out_valid && out_ready`
- `out_row`  out  [BIT_DEPTH-1:0] [MAX_SIZE]  reconstructed row; columns ≥ N are 0
- `out_row_idx`  out  5  index of the row in `out_row`
- `out_last`  out  1  high with row N-1

## Operation
- N = 4 << `transform_size`. Only rows and columns 0..N-1 are used. Inputs outside that region are ignored.
- States: IDLE, PREP, EMIT, DONE.
- IDLE with `start`=1: capture `residual_data`, `pred_data` and `transform_size` into internal buffers; go to PREP. Inputs are not sampled again until the next IDLE capture.
- PREP: load `out_row` with reconstructed row 0; set `out_row_idx`=0, `out_valid`=1, `out_last`=(N==1 ? never : 0); go to EMIT.
- EMIT, no handshake: hold `out_row`, `out_row_idx`, `out_last` and `out_valid` stable.
- EMIT, handshake, row < N-1: load row+1; keep `out_valid` high with no bubble; set `out_last`=1 when row+1 == N-1.
- EMIT, handshake, row == N-1: `out_valid`←0, `out_last`←0, `done`←1; go to DONE.
- DONE: when `start`=0, `done`←0 and go to IDLE. While `start` stays high, remain in DONE with `done` held high.
- `start` outside IDLE is ignored; it does not restart the block.
- Arithmetic per sample:
  - sum = sign-extended residual + zero-extended pred, width COEFF_WIDTH+1 signed.
  - sum < 0 → 0.
  - sum > 2^BIT_DEPTH-1 → 2^BIT_DEPTH-1.
  - Otherwise the low BIT_DEPTH bits of sum.
- Reset, including mid-block: state IDLE; `done`, `out_valid`, `out_last`, `out_row`, `out_row_idx` all 0. The row in flight is dropped and no partial `done` is produced.

## Timing
- `start` sampled at edge k → `out_valid` high after edge k+1 (row 0).
- Throughput: one row per cycle while `out_ready`=1.
- With `out_ready` held high, `done` rises after edge k+1+N.
- `done` falls one edge after `start` is seen low in DONE.
- Earliest re-capture: the edge after that.
- Output reset values: all 0.

## Structure
- Shared package `camera_decoder_pkg` holds:
  - `tsize_t` (2-bit size code)
  - function `tsize_to_n`
  - the recon state enum
  - constant `PIX_MAX`.
- Sub-module `recon_clip`: combinational add+clip of one sample (residual, pred → pixel). Instantiate MAX_SIZE times for the row datapath, with column ≥ N forced to 0.

## Test plan
- 4×4, `out_ready`=1, residual all +10, pred all 100 → 4 consecutive rows of 110, idx 0..3. `out_last` on idx 3; `done` after edge k+5.
- Clipping, BIT_DEPTH=8: residual -300 with pred 50 → 0; residual +200 with pred 200 → 255; residual -5 with pred 5 → 0. Columns 4..31 read 0.
- 32×32 with random `out_ready` (~50%) → 32 rows in order, each row stable while stalled, `done` only after the row-31 handshake.
- Change `start`, `residual_data` and `pred_data` during EMIT → output matches the originally captured block, with no restart.
- Assert `reset` mid-block at row 5 of 16×16 → next cycle all outputs 0 and state IDLE. A fresh `start` reconstructs the new block from row 0.
- Hold `start` high through completion → `done` stays 1 and there is no second block. Drop `start` → `done` falls the next edge; re-assert → a new capture proceeds normally.

Source files
------------

// File: rtl/camera_decoder_pkg.sv
// Shared types and helpers for the camera decoder reconstruction path.
//   tsize_t       : 2-bit transform size code (0->4, 1->8, 2->16, 3->32)
//   recon_state_e : residual_reconstruct control states
//   PIX_MAX       : largest pixel value at the default 8-bit depth
//   tsize_to_n    : size code to block edge length in samples
package camera_decoder_pkg;

  typedef logic [1:0] tsize_t;

  typedef enum logic [1:0] {
    StIdle,
    StPrep,
    StEmit,
    StDone
  } recon_state_e;

  localparam int unsigned PIX_BIT_DEPTH = 8;
  localparam int unsigned PIX_MAX       = (1 << PIX_BIT_DEPTH) - 1;

  function automatic logic [5:0] tsize_to_n(tsize_t t);
    return 6'd4 << t;
  endfunction

endpackage

// File: rtl/recon_clip.sv
// Combinational reconstruction of one sample: signed residual plus unsigned
// prediction, clipped to [0, 2^BIT_DEPTH-1].
//   residual_i : signed residual sample
//   pred_i     : unsigned prediction sample
//   pixel_o    : clipped reconstructed pixel
module recon_clip #(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned BIT_DEPTH   = 8
) (
  input  logic signed [COEFF_WIDTH-1:0] residual_i,
  input  logic        [BIT_DEPTH-1:0]   pred_i,
  output logic        [BIT_DEPTH-1:0]   pixel_o
);

  localparam int unsigned SumW = COEFF_WIDTH + 1;
  localparam logic signed [SumW-1:0] PixMax = SumW'((1 << BIT_DEPTH) - 1);

  logic signed [SumW-1:0] sum;

  always_comb begin
    // Residual sign-extends, prediction zero-extends; one extra bit avoids overflow.
    sum = SumW'(residual_i) + SumW'(pred_i);
    if (sum < 0) begin
      pixel_o = '0;
    end else if (sum > PixMax) begin
      pixel_o = '1;
    end else begin
      pixel_o = sum[BIT_DEPTH-1:0];
    end
  end

endmodule

// File: rtl/residual_reconstruct.sv
// Block reconstruction: captures a residual block, a prediction block and the
// block size on start, then streams clipped residual+prediction rows, one per
// cycle, over a valid/ready interface.
//   clk, reset              : clock, async active-high reset
//   start / done            : block request / completion (done held until start low)
//   transform_size          : size code captured with start
//   residual_data/pred_data : input blocks, captured in IDLE only
//   out_valid/out_ready     : row handshake
//   out_row/out_row_idx     : reconstructed row (cols >= N are 0) and its index
//   out_last                : marks row N-1
module residual_reconstruct
  import camera_decoder_pkg::*;
#(
  parameter int unsigned COEFF_WIDTH = 16,
  parameter int unsigned MAX_SIZE    = 32,
  parameter int unsigned BIT_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  output logic                          done,
  input  logic [1:0]                    transform_size,
  input  logic signed [COEFF_WIDTH-1:0] residual_data [MAX_SIZE][MAX_SIZE],
  input  logic [BIT_DEPTH-1:0]          pred_data [MAX_SIZE][MAX_SIZE],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BIT_DEPTH-1:0]          out_row [MAX_SIZE],
  output logic [4:0]                    out_row_idx,
  output logic                          out_last
);

  localparam int unsigned IdxW = 5;

  recon_state_e state_q, state_d;
  tsize_t       tsize_q;

  logic signed [COEFF_WIDTH-1:0] res_q  [MAX_SIZE][MAX_SIZE];
  logic [BIT_DEPTH-1:0]          pred_q [MAX_SIZE][MAX_SIZE];

  logic [BIT_DEPTH-1:0] out_row_q [MAX_SIZE];
  logic [BIT_DEPTH-1:0] out_row_d [MAX_SIZE];
  logic [IdxW-1:0]      out_row_idx_q, out_row_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 done_q, done_d;

  logic [5:0]           n;
  logic [IdxW-1:0]      last_idx;
  logic [IdxW-1:0]      row_sel;
  logic                 capture;
  logic                 handshake;
  logic [BIT_DEPTH-1:0] clip_pix [MAX_SIZE];

  assign n         = tsize_to_n(tsize_q);
  assign last_idx  = IdxW'(n - 6'd1);
  assign capture   = (state_q == StIdle) && start;
  assign handshake = out_valid_q && out_ready;
  // Row being prepared: row 0 in PREP, otherwise the row after the one on the port.
  assign row_sel   = (state_q == StPrep) ? '0 : out_row_idx_q + IdxW'(1);

  for (genvar c = 0; c < MAX_SIZE; c++) begin : g_col
    recon_clip #(
      .COEFF_WIDTH(COEFF_WIDTH),
      .BIT_DEPTH  (BIT_DEPTH)
    ) u_clip (
      .residual_i(res_q[row_sel][c]),
      .pred_i    (pred_q[row_sel][c]),
      .pixel_o   (clip_pix[c])
    );
  end

  // Input block buffers; written only on the IDLE capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tsize_q <= '0;
      for (int r = 0; r < int'(MAX_SIZE); r++) begin
        for (int c = 0; c < int'(MAX_SIZE); c++) begin
          res_q[r][c]  <= '0;
          pred_q[r][c] <= '0;
        end
      end
    end else if (capture) begin
      tsize_q <= transform_size;
      res_q   <= residual_data;
      pred_q  <= pred_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StPrep;
      StPrep: state_d = StEmit;
      StEmit: if (handshake && (out_row_idx_q == last_idx)) state_d = StDone;
      StDone: if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next-state logic.
  always_comb begin
    out_row_d     = out_row_q;
    out_row_idx_d = out_row_idx_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    done_d        = done_q;
    unique case (state_q)
      StPrep: begin
        for (int c = 0; c < int'(MAX_SIZE); c++) begin
          out_row_d[c] = (c < int'(n)) ? clip_pix[c] : '0;
        end
        out_row_idx_d = '0;
        out_valid_d   = 1'b1;
        out_last_d    = 1'b0;
      end
      StEmit: begin
        if (handshake) begin
          if (out_row_idx_q == last_idx) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            for (int c = 0; c < int'(MAX_SIZE); c++) begin
              out_row_d[c] = (c < int'(n)) ? clip_pix[c] : '0;
            end
            out_row_idx_d = row_sel;
            out_last_d    = (row_sel == last_idx);
          end
        end
      end
      StDone: if (!start) done_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < int'(MAX_SIZE); c++) out_row_q[c] <= '0;
      out_row_idx_q <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      out_row_q     <= out_row_d;
      out_row_idx_q <= out_row_idx_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      done_q        <= done_d;
    end
  end

  assign out_row     = out_row_q;
  assign out_row_idx = out_row_idx_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign done        = done_q;

endmodule

// File: tb/tb_residual_reconstruct.sv
module tb_residual_reconstruct;

  localparam int CW = 16;
  localparam int MS = 32;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic reset, start, done, out_valid, out_ready, out_last;
  logic [1:0] transform_size;
  logic signed [CW-1:0] residual_data [MS][MS];
  logic [BD-1:0] pred_data [MS][MS];
  logic [BD-1:0] out_row [MS];
  logic [4:0] out_row_idx;

  always #5 clk = ~clk;

  residual_reconstruct #(
    .COEFF_WIDTH(CW),
    .MAX_SIZE   (MS),
    .BIT_DEPTH  (BD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .done          (done),
    .transform_size(transform_size),
    .residual_data (residual_data),
    .pred_data     (pred_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_row       (out_row),
    .out_row_idx   (out_row_idx),
    .out_last      (out_last)
  );

  typedef struct {
    logic [BD*MS-1:0] pix;
    int               idx;
    bit               last;
  } row_t;

  typedef struct {
    logic signed [CW-1:0] res;
    logic [BD-1:0]        pred;
    logic [BD-1:0]        exp_pix;
  } vec_t;

  row_t exp_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [BD*MS-1:0] act,
                       input logic [BD*MS-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BD*MS-1:0] pack_out();
    logic [BD*MS-1:0] r;
    for (int c = 0; c < MS; c++) r[c*BD +: BD] = out_row[c];
    return r;
  endfunction

  function automatic logic [BD-1:0] ref_pix(logic signed [CW-1:0] r, logic [BD-1:0] p);
    int s;
    s = int'(r) + int'(p);
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  task automatic fill_const(input logic signed [CW-1:0] r, input logic [BD-1:0] p);
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++) begin
        residual_data[i][j] = r;
        pred_data[i][j]     = p;
      end
  endtask

  task automatic fill_random();
    int v;
    for (int i = 0; i < MS; i++)
      for (int j = 0; j < MS; j++) begin
        v = int'($urandom_range(0, 1023)) - 512;
        residual_data[i][j] = v[CW-1:0];
        pred_data[i][j]     = 8'($urandom_range(0, 255));
      end
  endtask

  // Expected rows from the captured inputs, pushed at capture time.
  task automatic push_model(input int tsz);
    row_t row;
    int   n;
    n = 4 << tsz;
    for (int r = 0; r < n; r++) begin
      row.pix = '0;
      for (int c = 0; c < n; c++) row.pix[c*BD +: BD] = ref_pix(residual_data[r][c], pred_data[r][c]);
      row.idx  = r;
      row.last = (r == n - 1);
      exp_q.push_back(row);
    end
  endtask

  task automatic push_const(input int tsz, input logic [BD-1:0] p);
    row_t row;
    int   n;
    n = 4 << tsz;
    for (int r = 0; r < n; r++) begin
      row.pix = '0;
      for (int c = 0; c < n; c++) row.pix[c*BD +: BD] = p;
      row.idx  = r;
      row.last = (r == n - 1);
      exp_q.push_back(row);
    end
  endtask

  // Drive start before an edge in IDLE; returns just after the capture edge.
  task automatic start_block(input int tsz, input bit keep_start);
    transform_size = 2'(tsz);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
  endtask

  // Consume rows until done, comparing every valid cycle to the queue head.
  task automatic drain(input bit rand_ready, input int budget, input bit disturb,
                       output int cyc);
    bit got_done;
    got_done = 1'b0;
    cyc = 0;
    while (!got_done && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        got_done = 1'b1;
        check("valid_low_at_done", {255'd0, out_valid}, '0);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_row", {251'd0, out_row_idx}, {BD*MS{1'b1}});
        end else begin
          check("row_data", pack_out(), exp_q[0].pix);
          check("row_idx", {251'd0, out_row_idx}, (BD*MS)'(exp_q[0].idx));
          check("row_last", {255'd0, out_last}, {255'd0, exp_q[0].last});
          if (out_ready) void'(exp_q.pop_front());
        end
        if (disturb) begin
          start = 1'($urandom_range(0, 1));
          residual_data[$urandom_range(0, 7)][$urandom_range(0, 7)] = 16'sd300;
          pred_data[$urandom_range(0, 7)][$urandom_range(0, 7)]     = 8'd7;
        end
      end
    end
    check("done_seen", {255'd0, got_done}, 256'd1);
    check("rows_left", (BD*MS)'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  task automatic finish_block();
    start = 1'b0;
    @(posedge clk);
    #1;
    check("done_fall", {255'd0, done}, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {255'd0, out_valid}, '0);
    check({tag, "_done"}, {255'd0, done}, '0);
    check({tag, "_last"}, {255'd0, out_last}, '0);
    check({tag, "_idx"}, {251'd0, out_row_idx}, '0);
    check({tag, "_row"}, pack_out(), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  found;

    vecs[0] = '{16'sd10,    8'd100, 8'd110};
    vecs[1] = '{-16'sd300,  8'd50,  8'd0};
    vecs[2] = '{16'sd200,   8'd200, 8'd255};
    vecs[3] = '{-16'sd5,    8'd5,   8'd0};
    vecs[4] = '{16'sd155,   8'd100, 8'd255};
    vecs[5] = '{16'sd154,   8'd100, 8'd254};
    vecs[6] = '{-16'sd100,  8'd100, 8'd0};
    vecs[7] = '{-16'sd101,  8'd100, 8'd0};
    vecs[8] = '{16'sd32767, 8'd255, 8'd255};
    vecs[9] = '{-16'sd32768, 8'd0,  8'd0};

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    transform_size = 2'd0;
    fill_const(16'sd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Uniform 4x4 blocks: arithmetic and clipping corners.
    for (int i = 0; i < 10; i++) begin
      fill_const(vecs[i].res, vecs[i].pred);
      start_block(0, 1'b0);
      push_const(0, vecs[i].exp_pix);
      drain(1'b0, 50, 1'b0, cyc);
      if (i == 0) check("done_latency_4x4", (BD*MS)'(cyc), (BD*MS)'(5));
      finish_block();
    end

    // 32x32 random data with random backpressure.
    fill_random();
    start_block(3, 1'b0);
    push_model(3);
    drain(1'b1, 600, 1'b0, cyc);
    finish_block();

    // Input and start changes during EMIT must not affect the captured block.
    fill_random();
    start_block(1, 1'b0);
    push_model(1);
    drain(1'b1, 200, 1'b1, cyc);
    finish_block();

    // Reset mid-block at row 5 of a 16x16 block.
    fill_random();
    out_ready = 1'b1;
    start_block(2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_row_idx == 5'd5) found = 1'b1;
    end
    check("reached_row5", {255'd0, found}, 256'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", {255'd0, out_valid}, '0);
    fill_random();
    start_block(2, 1'b0);
    push_model(2);
    drain(1'b0, 100, 1'b0, cyc);
    check("done_latency_16x16", (BD*MS)'(cyc), (BD*MS)'(17));
    finish_block();

    // Start held high through completion: done holds, no second block.
    fill_random();
    start_block(0, 1'b1);
    push_model(0);
    drain(1'b0, 50, 1'b0, cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("done_held", {255'd0, done}, 256'd1);
      check("no_second_block", {255'd0, out_valid}, '0);
    end
    finish_block();
    fill_random();
    start_block(1, 1'b0);
    push_model(1);
    drain(1'b0, 50, 1'b0, cyc);
    check("done_latency_8x8", (BD*MS)'(cyc), (BD*MS)'(9));
    finish_block();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
